// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_sequencer: PC owner and imem fetch into the IF/ID slot, with a     |
// | one-entry skid buffer and redirect-driven discard of stale fetches.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] kill_count
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_KILL  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_kill_addr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;

  logic        w_in_fetch;
  logic        w_in_hold;
  logic        w_in_kill;
  logic        w_consume;
  logic        w_deliver;
  logic        w_kill_event;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;
  logic        unused_redirect_lsbs;

  assign w_in_fetch    = (r_state == S_FETCH);
  assign w_in_hold     = (r_state == S_HOLD);
  assign w_in_kill     = (r_state == S_KILL);
  assign w_consume     = if_valid && !stall;
  assign w_deliver     = if_valid && !stall && !redirect_valid;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_pc_plus4    = r_pc + 32'd4;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Every discarded memory response bumps kill_count exactly once.
  assign w_kill_event = (w_in_kill && imem_ack) ||
                        (redirect_valid && ((w_in_fetch && imem_ack) || w_in_hold));

  // In KILL the stale address stays on the bus so the request never changes mid-flight.
  assign imem_req  = !reset && (w_in_fetch || w_in_kill);
  assign imem_addr = w_in_kill ? r_kill_addr : r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_kill_addr  <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
      if_valid     <= 1'b0;
      if_pc        <= 32'd0;
      if_instr     <= 32'd0;
      fetch_count  <= '0;
      kill_count   <= '0;
    end else begin
      if (redirect_valid) begin
        r_pc         <= w_redirect_pc;
        if_valid     <= 1'b0;
        r_skid_pc    <= 32'd0;
        r_skid_instr <= 32'd0;
        case (r_state)
          S_FETCH: begin
            if (!imem_ack) begin
              r_kill_addr <= r_pc;
              r_state     <= S_KILL;
            end
          end
          S_HOLD:  r_state <= S_FETCH;
          S_KILL: begin
            if (imem_ack) r_state <= S_FETCH;
          end
          default: r_state <= S_FETCH;
        endcase
      end else begin
        case (r_state)
          S_FETCH: begin
            if (imem_ack) begin
              r_pc <= w_pc_plus4;
              if (!if_valid || w_consume) begin
                if_valid <= 1'b1;
                if_pc    <= r_pc;
                if_instr <= imem_rdata;
              end else begin
                r_skid_pc    <= r_pc;
                r_skid_instr <= imem_rdata;
                r_state      <= S_HOLD;
              end
            end else if (w_consume) begin
              if_valid <= 1'b0;
            end
          end
          S_HOLD: begin
            if (w_consume) begin
              if_pc    <= r_skid_pc;
              if_instr <= r_skid_instr;
              r_state  <= S_FETCH;
            end
          end
          S_KILL: begin
            if (imem_ack) r_state <= S_FETCH;
          end
          default: r_state <= S_FETCH;
        endcase
      end

      if (w_deliver && (fetch_count != '1)) fetch_count <= fetch_count + CNT_W'(1);
      if (w_kill_event && (kill_count != '1)) kill_count <= kill_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_sequencer: directed scenarios plus randomized stall/redirect/   |
// | latency traffic checked against an instruction-stream reference model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] fetch_count;
  logic [31:0] kill_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory responder configuration and state
  bit lat_rand = 1'b0;
  int lat_cfg  = 0;
  bit busy     = 1'b0;
  int cnt      = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .fetch_count(fetch_count), .kill_count(kill_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  // Instruction memory: acks after a per-request latency (0 = same cycle as request).
  always begin
    @(negedge clk);
    #1;
    if (reset || !imem_req) begin
      busy       = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end else begin
      if (!busy) begin
        busy = 1'b1;
        cnt  = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
      end
      if (cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        busy       = 1'b0;
      end else begin
        cnt        = cnt - 1;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
      end
    end
  end

  // Leaves the caller 2 time units after the negedge of the first post-reset cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk); #2;
    n_tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b valid=%b pc=%h instr=%h, required 0 0 0 0", imem_req, if_valid, if_pc, if_instr);
    end
    n_tests++;
    if (fetch_count !== 32'd0 || kill_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: fetch=%0d kill=%0d, required 0 0", fetch_count, kill_count);
    end
  endtask

  task automatic test_stream();
    lat_rand = 1'b0; lat_cfg = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL stream_addr: req=%b addr=%h, required 1 %h", imem_req, imem_addr, 32'(4 * k));
      end
      if (k >= 1) begin
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 1)) || if_instr !== mem_word(32'(4 * (k - 1)))) begin
          n_fail++;
          $display("FAIL stream_slot: valid=%b pc=%h instr=%h, required 1 %h %h", if_valid, if_pc, if_instr,
                   32'(4 * (k - 1)), mem_word(32'(4 * (k - 1))));
        end
      end
      if (k == 9) begin
        n_tests++;
        if (fetch_count !== 32'd8) begin
          n_fail++;
          $display("FAIL stream_count: fetch_count=%0d, required 8", fetch_count);
        end
      end
      @(negedge clk); #2;
    end
  endtask

  task automatic test_stall_skid();
    logic [31:0] f0;
    bit found = 1'b0;
    lat_rand = 1'b0; lat_cfg = 0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid && if_pc == 32'h10) found = 1'b1;
      else begin @(negedge clk); #2; end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL stall_reach: slot never held 0x10, last if_pc=%h", if_pc);
    end
    f0 = fetch_count;
    stall = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); #2;
      n_tests++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h10) begin
        n_fail++;
        $display("FAIL stall_hold: req=%b valid=%b pc=%h, required 0 1 00000010", imem_req, if_valid, if_pc);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #2;
    for (int j = 0; j < 3; j++) begin
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'(32'h10 + 4 * j) || if_instr !== mem_word(32'(32'h10 + 4 * j))) begin
        n_fail++;
        $display("FAIL stall_release: valid=%b pc=%h instr=%h, required 1 %h %h", if_valid, if_pc, if_instr,
                 32'(32'h10 + 4 * j), mem_word(32'(32'h10 + 4 * j)));
      end
      @(negedge clk); #2;
    end
    n_tests++;
    if (fetch_count !== f0 + 32'd3) begin
      n_fail++;
      $display("FAIL stall_count: fetch_count=%0d, required %0d", fetch_count, f0 + 32'd3);
    end
  endtask

  task automatic test_kill_latency();
    bit found = 1'b0;
    bit acked = 1'b0;
    lat_rand = 1'b0; lat_cfg = 3;
    do_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
      else begin @(negedge clk); #2; end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL kill_reach: no request for 0x8 seen, addr=%h", imem_addr);
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #2;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    for (int i = 0; i < 10 && !acked; i++) begin
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
        n_fail++;
        $display("FAIL kill_addr_stable: req=%b addr=%h, required 1 00000008", imem_req, imem_addr);
      end
      if (imem_ack) acked = 1'b1;
      else begin @(negedge clk); #2; end
    end
    @(negedge clk); #2;
    n_tests++;
    if (kill_count !== 32'd1 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL kill_resume: kill=%0d req=%b addr=%h, required 1 1 00000200", kill_count, imem_req, imem_addr);
    end
    for (int i = 0; i < 20 && !if_valid; i++) begin @(negedge clk); #2; end
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== mem_word(32'h200)) begin
      n_fail++;
      $display("FAIL kill_deliver: valid=%b pc=%h instr=%h, required 1 00000200 %h", if_valid, if_pc, if_instr, mem_word(32'h200));
    end
  endtask

  task automatic test_redirect_ack_stall();
    logic [31:0] k0;
    lat_rand = 1'b0; lat_cfg = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin @(negedge clk); #2; end
    k0 = kill_count;
    n_tests++;
    if (imem_ack !== 1'b1 || if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ras_setup: ack=%b valid=%b, required 1 1", imem_ack, if_valid);
    end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0;
    #2;
    n_tests++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40 || kill_count !== k0 + 32'd1) begin
      n_fail++;
      $display("FAIL ras_flush: valid=%b req=%b addr=%h kill=%0d, required 0 1 00000040 %0d",
               if_valid, imem_req, imem_addr, kill_count, k0 + 32'd1);
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); #2;
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'(32'h40 + 4 * j)) begin
        n_fail++;
        $display("FAIL ras_stream: valid=%b pc=%h, required 1 %h", if_valid, if_pc, 32'(32'h40 + 4 * j));
      end
    end
  endtask

  task automatic test_double_redirect();
    bit saw_100 = 1'b0;
    logic [31:0] first_new = 32'hFFFF_FFFF;
    lat_rand = 1'b0; lat_cfg = 3;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_pc = 32'h300;
    #2;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    for (int i = 0; i < 30 && !if_valid; i++) begin
      if (imem_req && imem_addr == 32'h100) saw_100 = 1'b1;
      if (imem_req && imem_addr != 32'h0 && first_new == 32'hFFFF_FFFF) first_new = imem_addr;
      @(negedge clk); #2;
    end
    n_tests++;
    if (saw_100 !== 1'b0 || first_new !== 32'h300) begin
      n_fail++;
      $display("FAIL double_redirect_req: saw_0x100=%b first_new_addr=%h, required 0 00000300", saw_100, first_new);
    end
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h300 || kill_count !== 32'd1) begin
      n_fail++;
      $display("FAIL double_redirect_deliver: valid=%b pc=%h kill=%0d, required 1 00000300 1", if_valid, if_pc, kill_count);
    end
  endtask

  task automatic test_wrap();
    lat_rand = 1'b0; lat_cfg = 0;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_addr: req=%b addr=%h, required 1 fffffffc", imem_req, imem_addr);
    end
    @(negedge clk); #2;
    n_tests++;
    if (if_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: if_pc=%h addr=%h, required fffffffc 00000000", if_pc, imem_addr);
    end
    @(negedge clk); #2;
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin
      n_fail++;
      $display("FAIL wrap_deliver: valid=%b pc=%h instr=%h, required 1 00000000 %h", if_valid, if_pc, if_instr, mem_word(32'h0));
    end
  endtask

  task automatic test_reset_in_hold();
    lat_rand = 1'b0; lat_cfg = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin @(negedge clk); #2; end
    stall = 1'b1;
    @(negedge clk); #2;
    n_tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rsthold_enter: req=%b valid=%b, required 0 1", imem_req, if_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    #2;
    @(negedge clk); #2;
    n_tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0 ||
        fetch_count !== 32'd0 || kill_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rsthold_state: req=%b valid=%b pc=%h instr=%h fetch=%0d kill=%0d, required all 0",
               imem_req, if_valid, if_pc, if_instr, fetch_count, kill_count);
    end
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;
    #2;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rsthold_restart: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
  endtask

  // Reference model: the delivered stream is sequential from the last redirect target.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    bit          prev_pending = 1'b0;
    int          n_del = 0;
    lat_rand = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (prev_pending) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL rand_req_hold: req=%b addr=%h, required 1 %h", imem_req, imem_addr, prev_addr);
        end
      end
      stall          = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 7);
      redirect_pc    = $urandom;
      if (if_valid && !stall && !redirect_valid) begin
        n_tests++;
        if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
          n_fail++;
          $display("FAIL rand_deliver: pc=%h instr=%h, required %h %h", if_pc, if_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      prev_pending = imem_req && !imem_ack;
      prev_addr    = imem_addr;
      @(negedge clk); #2;
    end
    stall = 1'b0; redirect_valid = 1'b0;
    n_tests++;
    if (fetch_count !== 32'(n_del) || n_del == 0) begin
      n_fail++;
      $display("FAIL rand_fetch_count: fetch_count=%0d, required %0d (nonzero)", fetch_count, n_del);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_kill_latency();
    test_redirect_ack_stall();
    test_double_redirect();
    test_wrap();
    test_reset_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch from the instruction memory port into the IF/ID slot.
- Accepts next-PC redirects that decode computes from the prior instruction (jr target, taken beq/bne target, j/jal target).
- Handles downstream stalls with a one-entry skid buffer and discards in-flight fetches made stale by a redirect.
- Sits between the imem port and the decode stage; one outstanding memory request at most.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (low 2 bits must be 0)
- CNT_W, 32, width of performance counters

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- imem_req  output  1  fetch request; held until imem_ack
- imem_addr  output  32  fetch address; stable while imem_req high
- imem_ack  input  1  request complete, imem_rdata valid this cycle (may be the same cycle as imem_req rising)
- imem_rdata  input  32  fetched instruction word
- stall  input  1  decode cannot accept IF/ID slot this cycle
- redirect_valid  input  1  decode resolved a control transfer this cycle
- redirect_pc  input  32  new fetch address (low 2 bits ignored, treated as 0)
- if_valid  output  1  IF/ID slot holds a live instruction
- if_pc  output  32  address of if_instr
- if_instr  output  32  instruction word
- fetch_count  output  CNT_W  instructions delivered to decode (if_valid && !stall && !redirect_valid)
- kill_count  output  CNT_W  fetches discarded due to redirect

Behaviour:
- Reset (synchronous, sampled at posedge clk): pc=RESET_PC, state=FETCH, if_valid=0, if_pc=0, if_instr=0, skid empty, both counters 0. imem_req is forced to 0 while reset is high. First request (addr=RESET_PC) occurs in the first cycle after reset deasserts.
- Consume: slot consumed in a cycle when if_valid && !stall.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0. Data is waiting in the skid buffer.
  - KILL: imem_req=1, imem_addr = address of the stale outstanding request. Returned data is dropped.
- FETCH, ack, slot free or consumed this cycle: slot <= {pc, rdata}, if_valid=1, pc <= pc+4. Stay in FETCH. Back-to-back acks give 1 instruction per cycle.
- FETCH, ack, slot full and not consumed: skid <= {pc, rdata}, pc <= pc+4, go to HOLD.
- HOLD: when the slot is consumed, slot <= skid, skid empty, go to FETCH.
- Not consumed and no redirect: the slot holds its value unchanged.
- Redirect has priority over all other events in the same cycle:
  - pc <= {redirect_pc[31:2], 2'b00}; if_valid <= 0; skid cleared.
  - From FETCH without ack: go to KILL. imem_addr stays the old address until ack (never change the address mid-request).
  - From FETCH with ack the same cycle: data dropped, kill_count+1, stay in FETCH (new address next cycle).
  - From HOLD: skid dropped, kill_count+1, go to FETCH.
  - From KILL: pc updated again, stay in KILL.
- KILL, ack: data dropped, kill_count+1, go to FETCH with the current pc. Fetch resumes next cycle.
- Redirect while stall=1: the slot is still flushed. Stall does not block redirect.
- Counters: pc arithmetic is mod 2^32 (32'hFFFF_FFFC+4 = 0). Counters saturate at all-ones.
- Invariants:
  - Never more than one request outstanding.
  - The IF/ID pair (if_pc, if_instr) is always a matching pair.
  - No instruction is delivered twice or skipped, except by redirect.

Test Plan:
- Reset release, imem_ack tied high, stall=0 -> imem_addr 0,4,8,... on consecutive cycles; if_pc trails imem_addr by 1 cycle; fetch_count=8 after 8 delivered cycles.
- stall=1 for 3 cycles while if_pc=0x10 -> slot holds 0x10, skid captures 0x14, imem_req=0 during HOLD. After release, decode sees 0x10, 0x14, 0x18 with no gaps or duplicates.
- imem_ack latency 3, redirect_valid with redirect_pc=0x200 one cycle after request for 0x8 -> imem_addr stays 0x8 until ack, data dropped, kill_count=1, next request addr=0x200, if_pc=0x200 delivered.
- Redirect coincident with imem_ack and stall=1 -> if_valid=0 next cycle, skid empty, next imem_addr=redirect target, kill_count+1.
- Two redirects (0x100 then 0x300) while in KILL -> only 0x300 is fetched; 0x100 is never requested.
- redirect_pc=0xFFFF_FFFE -> fetch at 0xFFFF_FFFC, then wraps to 0x0000_0000. Separately, reset asserted mid-HOLD -> all outputs return to reset values next cycle, imem_req=0.
